// File: rtl/pc_seq_pkg.sv
// Shared types for the 8-bit PC sequencer: FSM states, next-PC select codes, PC width.
package pc_seq_pkg;
   localparam int PC_W = 8;

   typedef enum logic {
      S_SETTLE,
      S_ISSUE
   } state_t;

   typedef enum logic [1:0] {
      SEL_INC,
      SEL_TARGET,
      SEL_POP
   } sel_t;
endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses with push/pop, full/empty and occupancy level.
// Contents are not reset; only the level is, which empties the stack.
module pc_return_stack
   import pc_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = PC_W
) (
   input  logic                     i_clk,
   input  logic                     i_RESET,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_push_dat,
   output logic [W-1:0]             o_top_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int LVL_W = IDX_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [LVL_W-1:0] level_q, level_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign o_full  = (level_q == LVL_W'(DEPTH));
   assign o_empty = (level_q == '0);
   assign wr_idx  = level_q[IDX_W-1:0];
   // Garbage index when empty; callers never pop an empty stack.
   assign rd_idx  = IDX_W'(level_q - 1'b1);
   assign o_top_dat = mem_q[rd_idx];
   assign o_level   = level_q;

   always_comb begin
      level_d = level_q;
      if (i_push && !o_full) begin
         level_d = level_q + 1'b1;
      end else if (i_pop && !o_empty) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) begin
         mem_q[wr_idx] <= i_push_dat;
      end
   end
endmodule

// File: rtl/pc_sequencer_8_bit.sv
// Registered 8-bit PC sequencer: one fetch per two cycles over valid/ready, next PC from incrementer,
// jump/call target or return stack. Return stack and its status outputs exist only with PC_STACK_EN.
module pc_sequencer_8_bit
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC    = 8'h00,
   parameter int              STACK_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_RESET,
   input  logic [PC_W-1:0]               i_inc,
   output logic [PC_W-1:0]               o_pc,
   output logic                          o_pc_valid,
   input  logic                          i_fetch_ready,
   input  logic                          i_jump,
   input  logic                          i_call,
   input  logic                          i_ret,
   input  logic [PC_W-1:0]               i_target,
   output logic                          o_wrap,
   output logic [$clog2(STACK_DEPTH):0]  o_stack_level,
   output logic                          o_stack_err
);
   localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;
   logic            handshake;
   sel_t            sel;

   assign handshake = (state_q == S_ISSUE) && i_fetch_ready;

`ifdef PC_STACK_EN
   logic             stk_push, stk_pop, stk_full, stk_empty;
   logic             err_q, err_d;
   logic [PC_W-1:0]  stk_top;
   logic [LVL_W-1:0] stk_level;

   pc_return_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_stack (
      .i_clk      (i_clk),
      .i_RESET    (i_RESET),
      .i_push     (stk_push),
      .i_pop      (stk_pop),
      .i_push_dat (i_inc),
      .o_top_dat  (stk_top),
      .o_full     (stk_full),
      .o_empty    (stk_empty),
      .o_level    (stk_level)
   );

   // A ret on an empty stack falls through to the sequential path, not to call/jump.
   always_comb begin
      sel      = SEL_INC;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      err_d    = err_q;
      if (handshake) begin
         if (i_ret && !stk_empty) begin
            sel     = SEL_POP;
            stk_pop = 1'b1;
         end else if (i_ret) begin
            err_d = 1'b1;
         end else if (i_call || i_jump) begin
            sel = SEL_TARGET;
            if (i_call) begin
               if (stk_full) begin
                  err_d = 1'b1;
               end else begin
                  stk_push = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      case (sel)
         SEL_TARGET: pc_nxt = i_target;
         SEL_POP:    pc_nxt = stk_top;
         default:    pc_nxt = i_inc;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_stack_level = stk_level;
   assign o_stack_err   = err_q;
`else
   logic ret_unused;
   assign ret_unused = i_ret;

   always_comb begin
      sel = SEL_INC;
      if (handshake && (i_call || i_jump)) begin
         sel = SEL_TARGET;
      end
   end

   assign pc_nxt        = (sel == SEL_TARGET) ? i_target : i_inc;
   assign o_stack_level = '0;
   assign o_stack_err   = 1'b0;
`endif

   // S_SETTLE gives the external incrementer one cycle to reflect the new PC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      case (state_q)
         S_SETTLE: begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
         end
         default: begin
            if (i_fetch_ready) begin
               state_d = S_SETTLE;
               valid_d = 1'b0;
               pc_d    = pc_nxt;
               wrap_d  = (sel == SEL_INC) && (pc_q == '1);
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) begin
         state_q <= S_SETTLE;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_pc       = pc_q;
   assign o_pc_valid = valid_q;
   assign o_wrap     = wrap_q;
endmodule

// File: tb/tb_pc_sequencer_8_bit.sv
// Scoreboard bench for pc_sequencer_8_bit; adapts to PC_STACK_EN.
module tb_pc_sequencer_8_bit;
   localparam logic [7:0] RST_PC = 8'h00;
   localparam int         DEPTH  = 4;
`ifdef PC_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_RESET = 1'b1;
   logic [7:0] i_inc;
   logic [7:0] o_pc;
   logic       o_pc_valid;
   logic       i_fetch_ready = 1'b0;
   logic       i_jump = 1'b0;
   logic       i_call = 1'b0;
   logic       i_ret = 1'b0;
   logic [7:0] i_target = 8'h00;
   logic       o_wrap;
   logic [2:0] o_stack_level;
   logic       o_stack_err;

   pc_sequencer_8_bit #(.RESET_PC(RST_PC), .STACK_DEPTH(DEPTH)) dut (
      .i_clk         (i_clk),
      .i_RESET       (i_RESET),
      .i_inc         (i_inc),
      .o_pc          (o_pc),
      .o_pc_valid    (o_pc_valid),
      .i_fetch_ready (i_fetch_ready),
      .i_jump        (i_jump),
      .i_call        (i_call),
      .i_ret         (i_ret),
      .i_target      (i_target),
      .o_wrap        (o_wrap),
      .o_stack_level (o_stack_level),
      .o_stack_err   (o_stack_err)
   );

   always #5 i_clk = ~i_clk;

   // Registered incrementer feeding the DUT.
   always @(posedge i_clk or posedge i_RESET) begin
      if (i_RESET) i_inc <= RST_PC + 8'd1;
      else         i_inc <= o_pc + 8'd1;
   end

   typedef struct {
      logic [7:0] pc;
      logic       wrap;
      int         level;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   bit         mon_en = 1'b0;

   // Reference model state.
   bit         m_issue = 1'b0;
   logic [7:0] m_pc = RST_PC;
   logic [7:0] m_stk[$];
   logic       m_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_hs(input bit jmp, input bit cl, input bit rt, input logic [7:0] tgt);
      exp_t e;
      bit   seq;
      seq = 1'b1;
      if (STK && rt && m_stk.size() > 0) begin
         m_pc = m_stk.pop_back();
         seq = 1'b0;
      end else if (STK && rt) begin
         m_err = 1'b1;
      end else if (cl || jmp) begin
         if (STK && cl) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 8'd1);
            else m_err = 1'b1;
         end
         m_pc = tgt;
         seq = 1'b0;
      end
      e.wrap = seq && (m_pc == 8'hFF);
      if (seq) m_pc = m_pc + 8'd1;
      e.pc    = m_pc;
      e.level = m_stk.size();
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   // One clock: drive inputs, advance model, wait for the edge.
   task automatic step(input bit rdy, input bit jmp, input bit cl, input bit rt,
                       input logic [7:0] tgt, output bit hs);
      i_fetch_ready = rdy;
      i_jump = jmp;
      i_call = cl;
      i_ret = rt;
      i_target = tgt;
      hs = 1'b0;
      if (!m_issue) begin
         m_issue = 1'b1;
      end else if (rdy) begin
         hs = 1'b1;
         m_issue = 1'b0;
         model_hs(jmp, cl, rt, tgt);
      end
      @(posedge i_clk);
      #1;
   endtask

   // Complete one handshake with the given controls; settle cycles get random junk controls.
   task automatic fetch(input bit jmp, input bit cl, input bit rt, input logic [7:0] tgt);
      bit hs;
      hs = 1'b0;
      while (!hs) begin
         if (!m_issue)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), hs);
         else
            step(1'b1, jmp, cl, rt, tgt, hs);
      end
   endtask

   // Monitor: pops one expectation per handshake the DUT performs.
   initial begin
      bit         prev_hs, prev_settle;
      logic [7:0] cur_pc;
      exp_t       e;
      prev_hs = 1'b0;
      prev_settle = 1'b0;
      cur_pc = RST_PC;
      forever begin
         @(negedge i_clk);
         if (!mon_en) begin
            prev_hs = 1'b0;
            prev_settle = 1'b0;
            cur_pc = RST_PC;
         end else begin
            if (prev_hs) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_handshake", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  cur_pc = e.pc;
                  check("hs_valid_drop", 32'(o_pc_valid), 32'd0);
                  check("hs_wrap", 32'(o_wrap), 32'(e.wrap));
                  check("hs_level", 32'(o_stack_level), 32'(e.level));
                  check("hs_err", 32'(o_stack_err), 32'(e.err));
               end
            end else if (prev_settle) begin
               check("settle_to_valid", 32'(o_pc_valid), 32'd1);
               check("wrap_idle", 32'(o_wrap), 32'd0);
            end
            check("pc", 32'(o_pc), 32'(cur_pc));
            prev_hs = o_pc_valid && i_fetch_ready;
            prev_settle = !o_pc_valid;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit hs;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_pc", 32'(o_pc), 32'(RST_PC));
      check("rst_valid", 32'(o_pc_valid), 32'd0);
      check("rst_wrap", 32'(o_wrap), 32'd0);
      check("rst_level", 32'(o_stack_level), 32'd0);
      check("rst_err", 32'(o_stack_err), 32'd0);
      i_RESET = 1'b0;
      mon_en = 1'b1;

      // Plain sequential run, then wrap through FF.
      repeat (3) fetch(1'b0, 1'b0, 1'b0, 8'h00);
      fetch(1'b1, 1'b0, 1'b0, 8'hFF);
      fetch(1'b0, 1'b0, 1'b0, 8'h00);
      fetch(1'b0, 1'b0, 1'b0, 8'h00);

      // Stall in S_ISSUE with a jump held: nothing may move.
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, hs);
      repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, hs);
      check("stall_valid", 32'(o_pc_valid), 32'd1);
      check("stall_pc", 32'(o_pc), 32'(m_pc));

      // Call/return round trip from 0x10.
      fetch(1'b1, 1'b0, 1'b0, 8'h10);
      fetch(1'b0, 1'b1, 1'b0, 8'h40);
      fetch(1'b0, 1'b0, 1'b1, 8'h00);

      // Overflow on the fifth nested call, underflow on the fifth return.
      for (int i = 0; i < 5; i++) fetch(1'b0, 1'b1, 1'b0, 8'(8'h20 + 8'(i * 16)));
      for (int i = 0; i < 5; i++) fetch(1'b0, 1'b0, 1'b1, 8'h00);

      // All three controls together with a non-empty stack.
      fetch(1'b0, 1'b1, 1'b0, 8'h55);
      fetch(1'b0, 1'b1, 1'b0, 8'h66);
      fetch(1'b1, 1'b1, 1'b1, 8'h77);

      // Randomized traffic, controls toggling every cycle.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
              8'($urandom), hs);
      end

      // Reset in S_ISSUE with two stacked addresses.
      while (m_stk.size() > 0) fetch(1'b0, 1'b0, 1'b1, 8'h00);
      fetch(1'b0, 1'b1, 1'b0, 8'h30);
      fetch(1'b0, 1'b1, 1'b0, 8'h50);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, hs);
      check("pre_rst_valid", 32'(o_pc_valid), 32'd1);
      check("pre_rst_level", 32'(o_stack_level), 32'(m_stk.size()));
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      #2;
      mon_en = 1'b0;
      i_RESET = 1'b1;
      #1;
      check("async_rst_pc", 32'(o_pc), 32'(RST_PC));
      check("async_rst_valid", 32'(o_pc_valid), 32'd0);
      check("async_rst_level", 32'(o_stack_level), 32'd0);
      check("async_rst_err", 32'(o_stack_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
